// File: rtl/flash_cfg_arbiter.sv
// Round-robin arbiter sharing the flash AXI4-Lite config port between host config (req0) and the image sequencer (req1).
// Optional busy-watchdog enabled by defining FLSH_ARB_TIMEOUT_EN (forced SLVERR completion after TIMEOUT_CYCLES).
module flash_cfg_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock_tlx,
    input  logic        reset,

    input  logic [1:0]  req0_devsel,
    input  logic [13:0] req0_addr,
    input  logic        req0_wren,
    input  logic [31:0] req0_wdata,
    input  logic        req0_rden,
    input  logic        req0_expand_enable,
    input  logic        req0_expand_dir,
    output logic [31:0] req0_rdata,
    output logic        req0_done,
    output logic [1:0]  req0_bresp,
    output logic [1:0]  req0_rresp,

    input  logic [1:0]  req1_devsel,
    input  logic [13:0] req1_addr,
    input  logic        req1_wren,
    input  logic [31:0] req1_wdata,
    input  logic        req1_rden,
    input  logic        req1_expand_enable,
    input  logic        req1_expand_dir,
    output logic [31:0] req1_rdata,
    output logic        req1_done,
    output logic [1:0]  req1_bresp,
    output logic [1:0]  req1_rresp,

    output logic [1:0]  cfg_flsh_devsel,
    output logic [13:0] cfg_flsh_addr,
    output logic        cfg_flsh_wren,
    output logic [31:0] cfg_flsh_wdata,
    output logic        cfg_flsh_rden,
    output logic        cfg_flsh_expand_enable,
    output logic        cfg_flsh_expand_dir,
    input  logic [31:0] flsh_cfg_rdata,
    input  logic        flsh_cfg_done,
    input  logic [1:0]  flsh_cfg_bresp,
    input  logic [1:0]  flsh_cfg_rresp,

    output logic        arb_owner,
    output logic        arb_busy,
    output logic        arb_proto_err,
    output logic        arb_timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("flash_cfg_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    state_t state_q;
    state_t state_d;

    logic req0_valid;
    logic req1_valid;
    logic rr_ptr;           // requester favoured when both are valid
    logic owner_held;
    logic grant_en;
    logic grant_id;
    logic complete;
    logic force_done;
    logic finish;
    logic tmo_hit;

    // A request is only valid when exactly one of wren/rden is asserted.
    assign req0_valid = req0_wren ^ req0_rden;
    assign req1_valid = req1_wren ^ req1_rden;

    assign owner_held = arb_owner ? (req1_wren | req1_rden) : (req0_wren | req0_rden);
    assign finish     = complete | force_done;
    assign arb_busy   = (state_q == ST_BUSY);

    // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        grant_en   = 1'b0;
        grant_id   = 1'b0;
        complete   = 1'b0;
        force_done = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req0_valid || req1_valid) begin
                    grant_en = 1'b1;
                    grant_id = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
                    state_d  = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A real completion in the expiry cycle takes precedence over the watchdog.
                if (flsh_cfg_done) begin
                    complete = 1'b1;
                    state_d  = ST_RELEASE;
                end else if (tmo_hit) begin
                    force_done = 1'b1;
                    state_d    = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!owner_held) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock_tlx) begin
        if (reset) begin
            state_q                <= ST_IDLE;
            arb_owner              <= 1'b0;
            rr_ptr                 <= 1'b0;
            cfg_flsh_devsel        <= 2'b00;
            cfg_flsh_addr          <= 14'h0;
            cfg_flsh_wren          <= 1'b0;
            cfg_flsh_wdata         <= 32'h0;
            cfg_flsh_rden          <= 1'b0;
            cfg_flsh_expand_enable <= 1'b0;
            cfg_flsh_expand_dir    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant_en) begin
                arb_owner              <= grant_id;
                rr_ptr                 <= ~grant_id;
                cfg_flsh_devsel        <= grant_id ? req1_devsel        : req0_devsel;
                cfg_flsh_addr          <= grant_id ? req1_addr          : req0_addr;
                cfg_flsh_wren          <= grant_id ? req1_wren          : req0_wren;
                cfg_flsh_wdata         <= grant_id ? req1_wdata         : req0_wdata;
                cfg_flsh_rden          <= grant_id ? req1_rden          : req0_rden;
                cfg_flsh_expand_enable <= grant_id ? req1_expand_enable : req0_expand_enable;
                cfg_flsh_expand_dir    <= grant_id ? req1_expand_dir    : req0_expand_dir;
            end else if (finish) begin
                cfg_flsh_wren <= 1'b0;
                cfg_flsh_rden <= 1'b0;
            end
        end
    end

    logic [31:0] fin_rdata;
    logic [1:0]  fin_bresp;
    logic [1:0]  fin_rresp;

    assign fin_rdata = complete ? flsh_cfg_rdata : 32'h0;
    assign fin_bresp = complete ? flsh_cfg_bresp : RESP_SLVERR;
    assign fin_rresp = complete ? flsh_cfg_rresp : RESP_SLVERR;

    // Response registers hold their value until the same requester's next completion.
    always_ff @(posedge clock_tlx) begin
        if (reset) begin
            req0_done  <= 1'b0;
            req0_rdata <= 32'h0;
            req0_bresp <= 2'b00;
            req0_rresp <= 2'b00;
            req1_done  <= 1'b0;
            req1_rdata <= 32'h0;
            req1_bresp <= 2'b00;
            req1_rresp <= 2'b00;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            if (finish && !arb_owner) begin
                req0_done  <= 1'b1;
                req0_rdata <= fin_rdata;
                req0_bresp <= fin_bresp;
                req0_rresp <= fin_rresp;
            end
            if (finish && arb_owner) begin
                req1_done  <= 1'b1;
                req1_rdata <= fin_rdata;
                req1_bresp <= fin_bresp;
                req1_rresp <= fin_rresp;
            end
        end
    end

    always_ff @(posedge clock_tlx) begin
        if (reset) begin
            arb_proto_err <= 1'b0;
        end else begin
            arb_proto_err <= (req0_wren & req0_rden) | (req1_wren & req1_rden);
        end
    end

`ifdef FLSH_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] tmo_cnt;

    // Counter value equals the number of completed BUSY cycles; expiry fires in the last allowed one.
    assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock_tlx) begin
        if (reset || grant_en) begin
            tmo_cnt <= '0;
        end else if (state_q == ST_BUSY) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock_tlx) begin
        if (reset) begin
            arb_timeout <= 1'b0;
        end else if (force_done) begin
            arb_timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit     = 1'b0;
    assign arb_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_flash_cfg_arbiter.sv
// Directed self-checking bench for flash_cfg_arbiter; timeout scenario runs when FLSH_ARB_TIMEOUT_EN is defined.
module tb_flash_cfg_arbiter;

    logic        clock_tlx;
    logic        reset;
    logic [1:0]  req0_devsel, req1_devsel;
    logic [13:0] req0_addr, req1_addr;
    logic        req0_wren, req1_wren, req0_rden, req1_rden;
    logic [31:0] req0_wdata, req1_wdata;
    logic        req0_expand_enable, req1_expand_enable, req0_expand_dir, req1_expand_dir;
    logic [31:0] req0_rdata, req1_rdata;
    logic        req0_done, req1_done;
    logic [1:0]  req0_bresp, req1_bresp, req0_rresp, req1_rresp;
    logic [1:0]  cfg_flsh_devsel;
    logic [13:0] cfg_flsh_addr;
    logic        cfg_flsh_wren, cfg_flsh_rden, cfg_flsh_expand_enable, cfg_flsh_expand_dir;
    logic [31:0] cfg_flsh_wdata;
    logic [31:0] flsh_cfg_rdata;
    logic        flsh_cfg_done;
    logic [1:0]  flsh_cfg_bresp, flsh_cfg_rresp;
    logic        arb_owner, arb_busy, arb_proto_err, arb_timeout;

    int n_vec  = 0;
    int n_miss = 0;
    int req0_done_cnt = 0;
    int req1_done_cnt = 0;
    int base0;
    int base1;

    flash_cfg_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clock_tlx(clock_tlx), .reset(reset),
        .req0_devsel(req0_devsel), .req0_addr(req0_addr), .req0_wren(req0_wren), .req0_wdata(req0_wdata),
        .req0_rden(req0_rden), .req0_expand_enable(req0_expand_enable), .req0_expand_dir(req0_expand_dir),
        .req0_rdata(req0_rdata), .req0_done(req0_done), .req0_bresp(req0_bresp), .req0_rresp(req0_rresp),
        .req1_devsel(req1_devsel), .req1_addr(req1_addr), .req1_wren(req1_wren), .req1_wdata(req1_wdata),
        .req1_rden(req1_rden), .req1_expand_enable(req1_expand_enable), .req1_expand_dir(req1_expand_dir),
        .req1_rdata(req1_rdata), .req1_done(req1_done), .req1_bresp(req1_bresp), .req1_rresp(req1_rresp),
        .cfg_flsh_devsel(cfg_flsh_devsel), .cfg_flsh_addr(cfg_flsh_addr), .cfg_flsh_wren(cfg_flsh_wren),
        .cfg_flsh_wdata(cfg_flsh_wdata), .cfg_flsh_rden(cfg_flsh_rden),
        .cfg_flsh_expand_enable(cfg_flsh_expand_enable), .cfg_flsh_expand_dir(cfg_flsh_expand_dir),
        .flsh_cfg_rdata(flsh_cfg_rdata), .flsh_cfg_done(flsh_cfg_done), .flsh_cfg_bresp(flsh_cfg_bresp),
        .flsh_cfg_rresp(flsh_cfg_rresp),
        .arb_owner(arb_owner), .arb_busy(arb_busy), .arb_proto_err(arb_proto_err), .arb_timeout(arb_timeout)
    );

    initial begin
        clock_tlx = 1'b0;
        forever #5 clock_tlx = ~clock_tlx;
    end

    always @(negedge clock_tlx) begin
        if (req0_done === 1'b1) req0_done_cnt++;
        if (req1_done === 1'b1) req1_done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock_tlx);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic flash_done(input logic [31:0] rd, input logic [1:0] br, input logic [1:0] rr);
        flsh_cfg_done  = 1'b1;
        flsh_cfg_rdata = rd;
        flsh_cfg_bresp = br;
        flsh_cfg_rresp = rr;
        tick();
        flsh_cfg_done  = 1'b0;
        flsh_cfg_rdata = 32'hDEAD_BEEF;
        flsh_cfg_bresp = 2'b11;
        flsh_cfg_rresp = 2'b11;
    endtask

    initial begin
        reset = 1'b1;
        req0_devsel = 2'd0; req0_addr = 14'h0; req0_wren = 1'b0; req0_wdata = 32'h0; req0_rden = 1'b0;
        req0_expand_enable = 1'b0; req0_expand_dir = 1'b0;
        req1_devsel = 2'd0; req1_addr = 14'h0; req1_wren = 1'b0; req1_wdata = 32'h0; req1_rden = 1'b0;
        req1_expand_enable = 1'b0; req1_expand_dir = 1'b0;
        flsh_cfg_rdata = 32'h0; flsh_cfg_done = 1'b0; flsh_cfg_bresp = 2'b00; flsh_cfg_rresp = 2'b00;
        tick();
        tick();
        check("rst_cfg_wren", cfg_flsh_wren, 0);
        check("rst_cfg_rden", cfg_flsh_rden, 0);
        check("rst_cfg_addr", cfg_flsh_addr, 0);
        check("rst_busy", arb_busy, 0);
        check("rst_owner", arb_owner, 0);
        check("rst_proto", arb_proto_err, 0);
        check("rst_timeout", arb_timeout, 0);
        check("rst_req0_done", req0_done, 0);
        reset = 1'b0;

        // Single read from req0
        base0 = req0_done_cnt;
        base1 = req1_done_cnt;
        req0_devsel = 2'd1; req0_addr = 14'h0010; req0_rden = 1'b1; req0_expand_enable = 1'b1;
        tick();
        check("t1_owner", arb_owner, 0);
        check("t1_busy", arb_busy, 1);
        check("t1_cfg_rden", cfg_flsh_rden, 1);
        check("t1_cfg_wren", cfg_flsh_wren, 0);
        check("t1_cfg_addr", cfg_flsh_addr, 32'h10);
        check("t1_cfg_devsel", cfg_flsh_devsel, 1);
        check("t1_cfg_expand", cfg_flsh_expand_enable, 1);
        req0_addr = 14'h3FFF;
        repeat (4) tick();
        check("t1_addr_stable", cfg_flsh_addr, 32'h10);
        check("t1_no_early_done", req0_done, 0);
        flash_done(32'h1234_5678, 2'b00, 2'b00);
        check("t1_req0_done", req0_done, 1);
        check("t1_req0_rdata", req0_rdata, 32'h1234_5678);
        check("t1_req0_rresp", req0_rresp, 0);
        check("t1_cfg_rden_drop", cfg_flsh_rden, 0);
        check("t1_busy_drop", arb_busy, 0);
        check("t1_req1_rdata", req1_rdata, 0);
        tick();
        check("t1_done_pulse", req0_done, 0);
        check("t1_rdata_hold", req0_rdata, 32'h1234_5678);
        tick();
        check("t1_no_regrant", cfg_flsh_rden, 0);
        req0_rden = 1'b0;
        req0_expand_enable = 1'b0;
        tick();
        check("t1_req0_pulses", req0_done_cnt - base0, 1);
        check("t1_req1_pulses", req1_done_cnt - base1, 0);

        // Flash done outside BUSY is ignored
        flsh_cfg_done = 1'b1; flsh_cfg_rdata = 32'hCAFE_F00D;
        tick();
        flsh_cfg_done = 1'b0;
        check("idle_done_req0", req0_done, 0);
        check("idle_done_req1", req1_done, 0);
        check("idle_done_rdata", req0_rdata, 32'h1234_5678);
        check("idle_done_busy", arb_busy, 0);

        // Round robin after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t2_rdata_reset", req0_rdata, 0);
        req0_devsel = 2'd0; req0_addr = 14'h0001; req0_rden = 1'b1;
        req1_devsel = 2'd2; req1_addr = 14'h0002; req1_rden = 1'b1;
        tick();
        check("t2_first_owner", arb_owner, 0);
        check("t2_first_addr", cfg_flsh_addr, 1);
        flash_done(32'h1111_1111, 2'b00, 2'b00);
        check("t2_req0_done", req0_done, 1);
        check("t2_req1_idle", req1_done, 0);
        req0_rden = 1'b0;
        tick();
        check("t2_gap_busy", arb_busy, 0);
        req0_rden = 1'b1;
        tick();
        check("t2_second_owner", arb_owner, 1);
        check("t2_second_addr", cfg_flsh_addr, 2);
        check("t2_second_devsel", cfg_flsh_devsel, 2);
        flash_done(32'h2222_2222, 2'b01, 2'b11);
        check("t2_req1_done", req1_done, 1);
        check("t2_req1_rdata", req1_rdata, 32'h2222_2222);
        check("t2_req1_rresp", req1_rresp, 3);
        check("t2_req1_bresp", req1_bresp, 1);
        check("t2_req0_quiet", req0_done, 0);
        check("t2_req0_hold", req0_rdata, 32'h1111_1111);
        req1_rden = 1'b0;
        tick();
        tick();
        check("t2_third_owner", arb_owner, 0);
        check("t2_third_addr", cfg_flsh_addr, 1);
        flash_done(32'h3333_3333, 2'b00, 2'b00);
        req0_rden = 1'b0;
        tick();
        check("t2_end_busy", arb_busy, 0);

        // req1 write queued behind req0
        req0_addr = 14'h0030; req0_rden = 1'b1;
        tick();
        req1_devsel = 2'd1; req1_addr = 14'h0200; req1_wdata = 32'hA5A5_A5A5; req1_wren = 1'b1;
        tick();
        check("t3_owner_kept", arb_owner, 0);
        check("t3_no_wren", cfg_flsh_wren, 0);
        flash_done(32'h4444_4444, 2'b00, 2'b00);
        check("t3_req0_done", req0_done, 1);
        check("t3_rel_wren", cfg_flsh_wren, 0);
        req0_rden = 1'b0;
        tick();
        check("t3_gap_wren", cfg_flsh_wren, 0);
        check("t3_gap_busy", arb_busy, 0);
        tick();
        check("t3_owner", arb_owner, 1);
        check("t3_cfg_wren", cfg_flsh_wren, 1);
        check("t3_cfg_rden", cfg_flsh_rden, 0);
        check("t3_cfg_addr", cfg_flsh_addr, 32'h200);
        check("t3_cfg_wdata", cfg_flsh_wdata, 32'hA5A5_A5A5);
        req1_wdata = 32'h0;
        tick();
        check("t3_wdata_stable", cfg_flsh_wdata, 32'hA5A5_A5A5);
        flash_done(32'h5555_5555, 2'b00, 2'b00);
        check("t3_req1_done", req1_done, 1);
        check("t3_req1_bresp", req1_bresp, 0);
        check("t3_cfg_wren_drop", cfg_flsh_wren, 0);
        req1_wren = 1'b0;
        tick();

        // Protocol error: wren and rden together
        req0_wren = 1'b1; req0_rden = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_proto_pulse", arb_proto_err, 1);
            check("t4_no_wren", cfg_flsh_wren, 0);
            check("t4_no_rden", cfg_flsh_rden, 0);
        end
        req0_wren = 1'b0; req0_rden = 1'b0;
        tick();
        check("t4_proto_clear", arb_proto_err, 0);
        check("t4_idle", arb_busy, 0);

`ifdef FLSH_ARB_TIMEOUT_EN
        req0_addr = 14'h0007; req0_rden = 1'b1;
        tick();
        repeat (15) tick();
        check("t5_pre_expiry", req0_done, 0);
        check("t5_still_busy", arb_busy, 1);
        tick();
        check("t5_forced_done", req0_done, 1);
        check("t5_rdata_zero", req0_rdata, 0);
        check("t5_rresp", req0_rresp, 2);
        check("t5_bresp", req0_bresp, 2);
        check("t5_flag", arb_timeout, 1);
        check("t5_rden_drop", cfg_flsh_rden, 0);
        flsh_cfg_done = 1'b1; flsh_cfg_rdata = 32'h7777_7777;
        tick();
        flsh_cfg_done = 1'b0;
        check("t5_late_done", req0_done, 0);
        check("t5_late_rdata", req0_rdata, 0);
        req0_rden = 1'b0;
        tick();
        req1_addr = 14'h0008; req1_rden = 1'b1;
        tick();
        flash_done(32'h8888_8888, 2'b00, 2'b00);
        check("t5_next_done", req1_done, 1);
        check("t5_next_rdata", req1_rdata, 32'h8888_8888);
        check("t5_next_rresp", req1_rresp, 0);
        check("t5_flag_sticky", arb_timeout, 1);
        req1_rden = 1'b0;
        tick();
`else
        req0_addr = 14'h0007; req0_rden = 1'b1;
        tick();
        repeat (20) tick();
        check("t5n_still_busy", arb_busy, 1);
        check("t5n_no_done", req0_done, 0);
        check("t5n_no_flag", arb_timeout, 0);
        flash_done(32'h7777_7777, 2'b00, 2'b00);
        check("t5n_done", req0_done, 1);
        check("t5n_rdata", req0_rdata, 32'h7777_7777);
        req0_rden = 1'b0;
        tick();
`endif

        // Reset while BUSY abandons the op
        req0_addr = 14'h0005; req0_rden = 1'b1;
        tick();
        req1_addr = 14'h0006; req1_rden = 1'b1;
        tick();
        base0 = req0_done_cnt;
        reset = 1'b1;
        req0_rden = 1'b0;
        tick();
        check("t6_rden_zero", cfg_flsh_rden, 0);
        check("t6_addr_zero", cfg_flsh_addr, 0);
        check("t6_busy_zero", arb_busy, 0);
        check("t6_owner_zero", arb_owner, 0);
        check("t6_req1_rdata_zero", req1_rdata, 0);
        reset = 1'b0;
        tick();
        check("t6_regrant_owner", arb_owner, 1);
        check("t6_regrant_busy", arb_busy, 1);
        check("t6_regrant_addr", cfg_flsh_addr, 6);
        check("t6_no_abandoned_done", req0_done_cnt - base0, 0);
        flash_done(32'h6666_6666, 2'b00, 2'b00);
        check("t6_req1_done", req1_done, 1);
        check("t6_req1_rdata", req1_rdata, 32'h6666_6666);
        req1_rden = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
